// File: rtl/writeback_stage_if.sv
// MEM -> WB retiring-instruction handshake bundle.
// master: MEM stage (producer); slave: writeback stage (consumer).
interface writeback_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic            in_ld_regfile;
  logic [2:0]      in_regfilemux_sel;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_alu_out;
  logic            in_br_en;
  logic [XLEN-1:0] in_u_imm;
  logic [XLEN-1:0] in_pc;

  modport master (
    output in_valid, in_rd, in_ld_regfile, in_regfilemux_sel, in_funct3,
           in_alu_out, in_br_en, in_u_imm, in_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_ld_regfile, in_regfilemux_sel, in_funct3,
           in_alu_out, in_br_en, in_u_imm, in_pc,
    output in_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// rv32i WB stage: waits for load data, aligns/extends it, drives the regfile write port.
// Optional retire counter on instret when WB_RETIRE_CNT_EN is defined (tied to 0 otherwise).
module writeback_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  writeback_stage_if.slave   mem_wb,
  input  logic               dmem_resp,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               ld_regfile,
  output logic [4:0]         rd,
  output logic [XLEN-1:0]    rd_data,
  output logic               retire,
  output logic [CNT_W-1:0]   instret
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t state, next_state;

  logic       hold_ld;
  logic [4:0] hold_rd;
  logic [2:0] hold_funct3;
  logic [1:0] hold_off;

  logic            accept, is_load, complete, capture;
  logic            c_ld;
  logic [4:0]      c_rd;
  logic [XLEN-1:0] c_data;

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  assign mem_wb.in_ready = (state == IDLE);
  assign accept  = mem_wb.in_valid && (state == IDLE);
  assign is_load = (mem_wb.in_regfilemux_sel == 3'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept && is_load && !dmem_resp) next_state = WAIT_MEM;
      WAIT_MEM: if (dmem_resp) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    complete = 1'b0;
    capture  = 1'b0;
    c_ld     = 1'b0;
    c_rd     = '0;
    c_data   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          complete = !is_load || dmem_resp;
          capture  = is_load && !dmem_resp;
          c_ld     = mem_wb.in_ld_regfile;
          c_rd     = mem_wb.in_rd;
          case (mem_wb.in_regfilemux_sel)
            3'd1:    c_data = {{(XLEN-1){1'b0}}, mem_wb.in_br_en};
            3'd2:    c_data = mem_wb.in_u_imm;
            3'd3:    c_data = load_ext(mem_wb.in_funct3, mem_wb.in_alu_out[1:0], dmem_rdata);
            3'd4:    c_data = mem_wb.in_pc + XLEN'(4);
            default: c_data = mem_wb.in_alu_out;
          endcase
        end
      end
      WAIT_MEM: begin
        complete = dmem_resp;
        c_ld     = hold_ld;
        c_rd     = hold_rd;
        c_data   = load_ext(hold_funct3, hold_off, dmem_rdata);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_regfile  <= 1'b0;
      retire      <= 1'b0;
      rd          <= '0;
      rd_data     <= '0;
      hold_ld     <= 1'b0;
      hold_rd     <= '0;
      hold_funct3 <= '0;
      hold_off    <= '0;
    end else begin
      ld_regfile <= complete && c_ld && (c_rd != 5'd0);
      retire     <= complete;
      // rd/rd_data keep their last written values between completions
      if (complete) begin
        rd      <= c_rd;
        rd_data <= c_data;
      end
      if (capture) begin
        hold_ld     <= mem_wb.in_ld_regfile;
        hold_rd     <= mem_wb.in_rd;
        hold_funct3 <= mem_wb.in_funct3;
        hold_off    <= mem_wb.in_alu_out[1:0];
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           instret <= '0;
    else if (complete) instret <= instret + 1'b1;
  end
`else
  assign instret = '0;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (WB) stage of the 5-stage rv32i pipeline.
- Accepts one retiring instruction per cycle from the MEM stage and finishes it:
  - waits for the data-cache response when the instruction is a load,
  - aligns and extends load data,
  - selects the writeback value.
- Drives the register-file write port consumed by the decode stage: ld_regfile, rd, rd_data.
- This is the producer side of the regfile write interface.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, width of the retire counter (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  WB can accept this cycle.
- in_rd  in  5  destination register index.
- in_ld_regfile  in  1  instruction writes rd (from control word).
- in_regfilemux_sel  in  3  writeback source: 0 alu, 1 br_en, 2 u_imm, 3 load, 4 pc+4.
- in_funct3  in  3  load width/sign.
- in_alu_out  in  32  ALU result; also the load address.
- in_br_en  in  1  compare result.
- in_u_imm  in  32  U-type immediate.
- in_pc  in  32  instruction PC.
- dmem_resp  in  1  data-cache response valid.
- dmem_rdata  in  32  data-cache read word.
- ld_regfile  out  1  regfile write enable (one-cycle pulse).
- rd  out  5  regfile write index.
- rd_data  out  32  regfile write data.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count (optional feature).

Behaviour:
- Reset (async, any state):
  - state=IDLE; the held instruction is discarded.
  - ld_regfile=0, rd=0, rd_data=0, retire=0, instret=0.
- FSM states: IDLE, WAIT_MEM. in_ready = (state==IDLE).
- Accept = in_valid && in_ready.
- IDLE, accept, sel!=3: complete. Outputs update at the next edge (1-cycle latency); stay in IDLE.
- IDLE, accept, sel==3, dmem_resp=1 in the same cycle: complete with load data; stay in IDLE.
- IDLE, accept, sel==3, dmem_resp=0:
  - capture rd, ld_regfile, funct3, alu_out[1:0] into hold registers;
  - go to WAIT_MEM.
- WAIT_MEM: in_valid is ignored.
  - dmem_resp=1: complete from the hold registers; return to IDLE. in_ready rises the cycle after resp.
- dmem_resp in IDLE with no load being accepted: ignored.
- Completion (registered at the edge):
  - retire=1 for that cycle;
  - ld_regfile = ld && (rd!=0);
  - rd = rd; rd_data = mux value.
- No completion in a cycle: ld_regfile=0, retire=0; rd and rd_data hold their last values.
- Mux values:
  - sel 0 or 5-7: alu_out.
  - sel 1: {31'b0, br_en}.
  - sel 2: u_imm.
  - sel 4: pc+4, modulo 2^32 (pc=FFFFFFFC gives 0).
- Load extension, off = alu_out[1:0]:
  - 000 lb: dmem_rdata[8*off+:8], sign-extended.
  - 100 lbu: same byte, zero-extended.
  - 001 lh: dmem_rdata[16*off[1]+:16], sign-extended; off[0] ignored.
  - 101 lhu: same halfword, zero-extended.
  - 010 lw and 011/110/111: dmem_rdata unchanged.
- Back-to-back non-loads: one completion per cycle, no bubbles.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: instret is a CNT_W-bit counter.
  - Increments by 1 on every retire pulse, including rd=x0 and non-writing instructions.
  - Wraps at 2^CNT_W to 0; reset to 0.
- Undefined: the instret port still exists, tied to 0; no counter flops are built.

Test Plan:
- Reset while in WAIT_MEM (load pending), then dmem_resp=1 -> state IDLE, ld_regfile=0, retire stays 0, no write.
- Back-to-back non-loads:
  - sel=0, rd=5, alu_out=0x1234 -> next cycle ld_regfile=1, rd=5, rd_data=0x1234;
  - sel=4, pc=0x100 -> next cycle rd_data=0x104.
- lb with funct3=000, alu_out[1:0]=2, dmem_rdata=0x0080FF00, resp the same cycle -> rd_data=0xFFFFFF80. lbu on the same inputs -> 0x00000080.
- lh with off=2, dmem_rdata=0x8001_0000, resp 3 cycles late:
  - in_ready=0 for 3 cycles;
  - then rd_data=0xFFFF8001 and a single ld_regfile pulse;
  - in_ready=1 the following cycle.
- rd=0, ld=1, sel=0 -> ld_regfile=0, retire=1. sel=1, br_en=1 -> rd_data=1.
- With WB_RETIRE_CNT_EN: 10 retires -> instret=10. Preload near 2^CNT_W-1, then 2 retires -> instret=1.
